// File: rtl/gene_net_sweep_ctrl_if.sv
// Handshake and datapath bundle for gene_net_sweep_ctrl.
// The slave modport is the controller's view; the master modport is the requester/datapath side.
interface gene_net_sweep_ctrl_if #(
  parameter int W = 8
);
  logic           start;
  logic [W-1:0]   seed_lo;
  logic [W-1:0]   seed_hi;
  logic           busy;
  logic           done;
  logic [W-1:0]   gn_x;
  logic [W-1:0]   gn_nx;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_seed;
  logic [W-1:0]   res_attr;
  logic [W:0]     res_period;
  logic [W:0]     fixed_cnt;
  logic [W:0]     cycle_cnt;

  modport slave (
    input  start, seed_lo, seed_hi, gn_nx, res_ready,
    output busy, done, gn_x, res_valid, res_seed, res_attr, res_period,
           fixed_cnt, cycle_cnt
  );

  modport master (
    output start, seed_lo, seed_hi, gn_nx, res_ready,
    input  busy, done, gn_x, res_valid, res_seed, res_attr, res_period,
           fixed_cnt, cycle_cnt
  );
endinterface

// File: rtl/gene_net_sweep_ctrl.sv
// Sweeps seeds through an external combinational gene_net step and classifies each attractor.
// Optional macro GN_SWEEP_EARLY_EXIT_EN: report a fixed point as soon as it is reached during warm-up.
module gene_net_sweep_ctrl #(
  parameter int W      = 8,
  parameter int WARMUP = 2**W
) (
  input  logic                  clk,
  input  logic                  rst,
  gene_net_sweep_ctrl_if.slave  bus
);

  localparam int STEP_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WARMUP - 1);
  localparam logic [W:0] ONE = (W+1)'(1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_WARM   = 3'd2;
  localparam logic [2:0] ST_MEAS   = 3'd3;
  localparam logic [2:0] ST_REPORT = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [W-1:0]      x_q, x_d;
  logic [W-1:0]      seed_q, seed_d;
  logic [W-1:0]      seedHi_q, seedHi_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [W-1:0]      ref_q, ref_d;
  logic [W-1:0]      min_q, min_d;
  logic [W:0]        per_q, per_d;
  logic [W:0]        period_q, period_d;
  logic [W-1:0]      attr_q, attr_d;
  logic [W:0]        fixedCnt_q, fixedCnt_d;
  logic [W:0]        cycleCnt_q, cycleCnt_d;
  logic [W-1:0]      minNext;

  assign minNext = (bus.gn_nx < min_q) ? bus.gn_nx : min_q;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    seed_d     = seed_q;
    seedHi_d   = seedHi_q;
    step_d     = step_q;
    ref_d      = ref_q;
    min_d      = min_q;
    per_d      = per_q;
    period_d   = period_q;
    attr_d     = attr_q;
    fixedCnt_d = fixedCnt_q;
    cycleCnt_d = cycleCnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          seed_d     = bus.seed_lo;
          seedHi_d   = bus.seed_hi;
          fixedCnt_d = '0;
          cycleCnt_d = '0;
          state_d    = (bus.seed_lo > bus.seed_hi) ? ST_DONE : ST_LOAD;
        end
      end

      ST_LOAD: begin
        x_d     = seed_q;
        step_d  = '0;
        state_d = ST_WARM;
      end

      // Warm-up puts the trajectory on its attractor; ref is the first on-attractor state.
      ST_WARM: begin
        x_d    = bus.gn_nx;
        step_d = step_q + 1'b1;
`ifdef GN_SWEEP_EARLY_EXIT_EN
        if (bus.gn_nx == x_q) begin
          attr_d   = x_q;
          period_d = ONE;
          state_d  = ST_REPORT;
        end else
`endif
        if (step_q == STEP_LAST) begin
          ref_d   = bus.gn_nx;
          min_d   = bus.gn_nx;
          per_d   = ONE;
          state_d = ST_MEAS;
        end
      end

      ST_MEAS: begin
        x_d   = bus.gn_nx;
        min_d = minNext;
        if (bus.gn_nx == ref_q) begin
          period_d = per_q;
          attr_d   = minNext;
          state_d  = ST_REPORT;
        end else begin
          per_d = per_q + 1'b1;
        end
      end

      // The last-seed test precedes the increment so seed_hi at the top of the range cannot wrap.
      ST_REPORT: begin
        if (bus.res_ready) begin
          if (period_q == ONE) fixedCnt_d = fixedCnt_q + 1'b1;
          else                 cycleCnt_d = cycleCnt_q + 1'b1;
          if (seed_q == seedHi_q) begin
            state_d = ST_DONE;
          end else begin
            seed_d  = seed_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      seed_q     <= '0;
      seedHi_q   <= '0;
      step_q     <= '0;
      ref_q      <= '0;
      min_q      <= '0;
      per_q      <= '0;
      period_q   <= '0;
      attr_q     <= '0;
      fixedCnt_q <= '0;
      cycleCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      seed_q     <= seed_d;
      seedHi_q   <= seedHi_d;
      step_q     <= step_d;
      ref_q      <= ref_d;
      min_q      <= min_d;
      per_q      <= per_d;
      period_q   <= period_d;
      attr_q     <= attr_d;
      fixedCnt_q <= fixedCnt_d;
      cycleCnt_q <= cycleCnt_d;
    end
  end

  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.res_valid  = (state_q == ST_REPORT);
  assign bus.gn_x       = x_q;
  assign bus.res_seed   = seed_q;
  assign bus.res_attr   = attr_q;
  assign bus.res_period = period_q;
  assign bus.fixed_cnt  = fixedCnt_q;
  assign bus.cycle_cnt  = cycleCnt_q;

endmodule

// File: tb/tb_gene_net_sweep_ctrl.sv
// Bench for gene_net_sweep_ctrl: stub next-state functions, a trajectory model and a per-cycle checker.
// Build with or without GN_SWEEP_EARLY_EXIT_EN; the model follows the same macro.
module tb_gene_net_sweep_ctrl;

  localparam int W      = 8;
  localparam int WARMUP = 2**W;

  typedef struct {
    logic [W-1:0] seed;
    logic [W-1:0] attr;
    logic [W:0]   per;
    int           lat;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   stubMode = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   doneCount = 0;
  int   runFixed = 0;
  int   runCycle = 0;
  int   launchCyc = 0;
  int   lastLat = 0;
  logic [W-1:0] lastSeed = '0;
  logic [W-1:0] lastAttr = '0;
  logic [W:0]   lastPeriod = '0;
  logic prevValid = 1'b0;
  logic prevReady = 1'b0;
  logic prevDone = 1'b0;
  res_t expQ[$];

  gene_net_sweep_ctrl_if #(.W(W)) bus ();

  gene_net_sweep_ctrl #(.W(W), .WARMUP(WARMUP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Stub datapaths: 0 identity, 1 increment, 2 invert, 3 shift right (reaches fixed point 0).
  function automatic logic [W-1:0] stubF(int m, logic [W-1:0] x);
    case (m)
      0:       return x;
      1:       return x + 1'b1;
      2:       return ~x;
      default: return x >> 1;
    endcase
  endfunction

  always_comb bus.gn_nx = stubF(stubMode, bus.gn_x);

  // Walk the trajectory in plain software to find the attractor, its minimum and length.
  function automatic res_t model(int m, logic [W-1:0] s);
    res_t r;
    logic [W-1:0] x, y, mn;
    int p;
    r.seed = s;
    x = s;
    for (int j = 0; j < WARMUP; j++) begin
`ifdef GN_SWEEP_EARLY_EXIT_EN
      if (stubF(m, x) == x) begin
        r.attr = x;
        r.per  = (W+1)'(1);
        r.lat  = j + 2;
        return r;
      end
`endif
      x = stubF(m, x);
    end
    mn = x;
    y  = stubF(m, x);
    p  = 1;
    while (y != x) begin
      if (y < mn) mn = y;
      y = stubF(m, y);
      p++;
    end
    r.attr = mn;
    r.per  = (W+1)'(p);
    r.lat  = WARMUP + p + 1;
    return r;
  endfunction

  task automatic checkOutput(string name, longint act, longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Per-cycle checker: counters, presented result, hold-under-backpressure, result timing and done pulse.
  always @(negedge clk) begin
    if (rst) begin
      prevValid = 1'b0;
      prevReady = 1'b0;
      prevDone  = 1'b0;
      runFixed  = 0;
      runCycle  = 0;
    end else begin
      checkOutput("fixedCnt", bus.fixed_cnt, runFixed);
      checkOutput("cycleCnt", bus.cycle_cnt, runCycle);
      if (bus.res_valid) begin
        checkOutput("busyWithValid", bus.busy, 1);
        checkOutput("resultExpected", expQ.size() > 0, 1);
        if (expQ.size() > 0) begin
          checkOutput("resSeed", bus.res_seed, expQ[0].seed);
          checkOutput("resAttr", bus.res_attr, expQ[0].attr);
          checkOutput("resPeriod", bus.res_period, expQ[0].per);
          if (!prevValid) begin
            lastLat = cyc - (launchCyc + 1);
            checkOutput("resLatency", lastLat, expQ[0].lat);
          end
          if (bus.res_ready) begin
            lastSeed   = expQ[0].seed;
            lastAttr   = bus.res_attr;
            lastPeriod = bus.res_period;
            if (expQ[0].per == 1) runFixed++;
            else                  runCycle++;
            void'(expQ.pop_front());
            launchCyc = cyc;
          end
        end
      end else if (prevValid && !prevReady) begin
        checkOutput("validHeld", bus.res_valid, 1);
      end
      if (bus.done) begin
        checkOutput("donePulse", prevDone, 0);
        checkOutput("busyWithDone", bus.busy, 1);
        doneCount++;
      end
      if (bus.start && !bus.busy) begin
        runFixed  = 0;
        runCycle  = 0;
        launchCyc = cyc;
      end
      prevValid = bus.res_valid;
      prevReady = bus.res_ready;
      prevDone  = bus.done;
    end
  end

  task automatic applyStimulus(int mode, int lo, int hi, int bp, bit injectStart);
    int budget, n, d0, bpLeft, totFixed, totCycle;
    res_t r;
    stubMode = mode;
    budget = 20;
    totFixed = 0;
    totCycle = 0;
    for (int s = lo; s <= hi; s++) begin
      r = model(mode, W'(s));
      expQ.push_back(r);
      if (r.per == 1) totFixed++;
      else            totCycle++;
      budget += r.lat + 3 + bp;
    end
    @(posedge clk); #1;
    bus.seed_lo   = W'(lo);
    bus.seed_hi   = W'(hi);
    bus.start     = 1'b1;
    bus.res_ready = (bp == 0);
    d0 = doneCount;
    bpLeft = bp;
    n = 0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (doneCount == d0 && n < budget) begin
      bus.start = (injectStart && n == 5);
      if (bus.start) begin
        bus.seed_lo = '0;
        bus.seed_hi = '1;
      end
      if (bpLeft > 0) begin
        bus.res_ready = 1'b0;
        if (bus.res_valid) bpLeft--;
      end else begin
        bus.res_ready = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    bus.res_ready = 1'b1;
    checkOutput("sweepDone", doneCount - d0, 1);
    @(negedge clk);
    checkOutput("idleBusy", bus.busy, 0);
    checkOutput("idleDone", bus.done, 0);
    checkOutput("resultsLeft", expQ.size(), 0);
    checkOutput("finalFixed", bus.fixed_cnt, totFixed);
    checkOutput("finalCycle", bus.cycle_cnt, totCycle);
    expQ.delete();
  endtask

  initial begin
    int d0;
    bus.start = 1'b0;
    bus.seed_lo = '0;
    bus.seed_hi = '0;
    bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstDone", bus.done, 0);
    checkOutput("rstValid", bus.res_valid, 0);
    checkOutput("rstGnX", bus.gn_x, 0);
    checkOutput("rstSeed", bus.res_seed, 0);
    checkOutput("rstAttr", bus.res_attr, 0);
    checkOutput("rstPeriod", bus.res_period, 0);
    checkOutput("rstFixed", bus.fixed_cnt, 0);
    checkOutput("rstCycle", bus.cycle_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] identity sweep 0x00..0xFF with a stray start");
    applyStimulus(0, 8'h00, 8'hFF, 0, 1'b1);
    checkOutput("idFixedLit", bus.fixed_cnt, 256);
    checkOutput("idCycleLit", bus.cycle_cnt, 0);
    checkOutput("idLastSeed", lastSeed, 8'hFF);
    checkOutput("idLastAttr", lastAttr, 8'hFF);
    checkOutput("idLastPeriod", lastPeriod, 1);
`ifdef GN_SWEEP_EARLY_EXIT_EN
    checkOutput("idLatLit", lastLat, 2);
`else
    checkOutput("idLatLit", lastLat, 258);
`endif

    $display("[TB] increment sweep 0x10..0x11");
    applyStimulus(1, 8'h10, 8'h11, 0, 1'b0);
    checkOutput("incCycleLit", bus.cycle_cnt, 2);
    checkOutput("incLastSeed", lastSeed, 8'h11);
    checkOutput("incLastAttr", lastAttr, 8'h00);
    checkOutput("incLastPeriod", lastPeriod, 256);

    $display("[TB] invert seed 0x3C, then 0xC3 under backpressure");
    applyStimulus(2, 8'h3C, 8'h3C, 0, 1'b0);
    checkOutput("inv3CAttr", lastAttr, 8'h3C);
    checkOutput("inv3CPeriod", lastPeriod, 2);
    applyStimulus(2, 8'hC3, 8'hC3, 10, 1'b0);
    checkOutput("invC3Attr", lastAttr, 8'h3C);
    checkOutput("invC3Seed", lastSeed, 8'hC3);

    $display("[TB] shift-right sweep 0x80..0x81");
    applyStimulus(3, 8'h80, 8'h81, 0, 1'b0);
    checkOutput("shrFixedLit", bus.fixed_cnt, 2);
    checkOutput("shrLastAttr", lastAttr, 8'h00);

    $display("[TB] empty sweep 0x05..0x04");
    applyStimulus(0, 8'h05, 8'h04, 0, 1'b0);
    checkOutput("emptyFixed", bus.fixed_cnt, 0);

    $display("[TB] reset during measurement");
    stubMode = 1;
    expQ.push_back(model(1, 8'h20));
    @(posedge clk); #1;
    bus.seed_lo = 8'h20;
    bus.seed_hi = 8'h20;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    d0 = doneCount;
    repeat (WARMUP + 20) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("abortBusy", bus.busy, 0);
    checkOutput("abortValid", bus.res_valid, 0);
    checkOutput("abortFixed", bus.fixed_cnt, 0);
    checkOutput("abortCycle", bus.cycle_cnt, 0);
    expQ.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abortNoDone", doneCount - d0, 0);
    applyStimulus(2, 8'h3C, 8'h3C, 0, 1'b0);
    checkOutput("afterRstAttr", lastAttr, 8'h3C);
    checkOutput("afterRstPeriod", lastPeriod, 2);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
